pdh_dma_arbiter: RTL
====================

PDH_DMA_ARBITER -- requirements
Module: pdh_dma_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the word width of the requester and DMA data ports.
REQ-002 The block SHALL have parameter BURST_WORDS, default 16, giving the maximum number of consecutive words granted to one requester before re-arbitration.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the watchdog limit used only when PDH_DMA_ARB_TIMEOUT_EN is defined.
REQ-004 The block SHALL have port aclk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid_i, input, width 2: per-requester word-available flags.
REQ-007 The block SHALL have port req_data_i, input, width 2*DATA_WIDTH: per-requester word, with requester n in bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready_o, output, width 2: per-requester accept; a transfer occurs on a cycle where valid and ready are both high.
REQ-009 The block SHALL have port dma_enable_o, output, width 1: word pending to the DMA controller.
REQ-010 The block SHALL have port dma_data_o, output, width DATA_WIDTH: pending word.
REQ-011 The block SHALL have port dma_finished_i, input, width 1: single-cycle pulse from the DMA controller meaning the word has been committed.
REQ-012 The block SHALL have port clr_i, input, width 1: synchronous clear of the counters and the error flag.
REQ-013 The block SHALL have port grant_o, output, width 1: index of the current or last-granted requester.
REQ-014 The block SHALL have port busy_o, output, width 1: high in any state other than IDLE.
REQ-015 The block SHALL have port cnt0_o, output, width 32: words from requester 0 committed by the DMA controller.
REQ-016 The block SHALL have port cnt1_o, output, width 32: words from requester 1 committed by the DMA controller.
REQ-017 The block SHALL have port err_timeout_o, output, width 1: sticky watchdog error flag.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, BUSY and NEXT.
REQ-019 In IDLE with no requester valid, the block SHALL hold all req_ready_o bits low and dma_enable_o low.
REQ-020 In IDLE with exactly one requester valid, the block SHALL grant that requester.
REQ-021 In IDLE with both requesters valid, the block SHALL grant the requester not equal to last_grant (round-robin).
REQ-022 On a grant in IDLE, the block SHALL assert req_ready_o[g] combinationally in the same cycle, latch the word into dma_data_o, set the beat counter to 1, and move to BUSY.
REQ-023 req_ready_o SHALL have at most one bit high in any cycle and SHALL be high only in the handshake cycle of IDLE or NEXT.
REQ-024 In BUSY, dma_enable_o SHALL be high and dma_data_o SHALL be stable, so dma_enable_o rises one cycle after the handshake.
REQ-025 In BUSY, when dma_finished_i is high, the block SHALL increment cnt[g] by 1 (wrapping 0xFFFFFFFF to 0) and move to NEXT.
REQ-026 dma_finished_i SHALL be ignored outside BUSY.
REQ-027 In NEXT, dma_enable_o SHALL be low, which guarantees at least one low cycle between words.
REQ-028 In NEXT, if the beat counter is below BURST_WORDS and req_valid_i[g] is high, the block SHALL perform the handshake, latch the word, increment the beat counter and move to BUSY.
REQ-029 In NEXT, if the beat counter has reached BURST_WORDS or req_valid_i[g] is low, the block SHALL set last_grant to g and move to IDLE; arbitration then occurs in the following cycle.
REQ-030 When clr_i is high, cnt0_o, cnt1_o and err_timeout_o SHALL be zeroed on the next edge, and clr_i SHALL take priority over a simultaneous increment.
REQ-031 clr_i SHALL NOT affect the state machine, the grant or the pending word.

Reset
REQ-032 While rst_ni is low, the block SHALL asynchronously force state IDLE, dma_enable_o=0, dma_data_o=0, req_ready_o=0, grant_o=0, last_grant=1, beat counter=0, busy_o=0, cnt0_o=0, cnt1_o=0 and err_timeout_o=0.
REQ-033 A reset asserted mid-word SHALL abandon the word without counting it, and requester 0 SHALL win the first arbitration after release.

Configuration
REQ-034 With macro PDH_DMA_ARB_TIMEOUT_EN defined, the block SHALL count consecutive BUSY cycles without dma_finished_i, and on reaching TIMEOUT_CYCLES it SHALL set err_timeout_o (sticky), leave the word uncounted, set last_grant to g and move to IDLE.
REQ-035 With PDH_DMA_ARB_TIMEOUT_EN undefined, err_timeout_o SHALL be tied to 0 and BUSY SHALL wait indefinitely for dma_finished_i.

Verification
REQ-036 The bench SHALL cover: both requesters continuously valid, BURST_WORDS=4, dma_finished_i 3 cycles after each enable -> grant sequence 0,0,0,0,1,1,1,1,0; cnt0_o=cnt1_o=4 after 8 words.
REQ-037 The bench SHALL cover: requester 1 alone sends 2 words then drops valid -> release after 2 words, cnt1_o=2, busy_o low 1 cycle after the second NEXT.
REQ-038 The bench SHALL cover: rst_ni pulsed low while in BUSY -> dma_enable_o low in the same cycle, no count change, next grant 0.
REQ-039 The bench SHALL cover: cnt0_o=0xFFFFFFFF and one more committed word -> cnt0_o=0; clr_i coincident with dma_finished_i -> counters read 0.
REQ-040 The bench SHALL cover: macro defined, TIMEOUT_CYCLES=8, dma_finished_i never pulsed -> err_timeout_o=1 after 8 BUSY cycles, state IDLE, count unchanged; clr_i -> err_timeout_o=0.
REQ-041 The bench SHALL cover: dma_finished_i pulsed in IDLE or NEXT -> no counter change, no state change.

Source files
------------

// File: rtl/pdh_dma_arbiter_if.sv
// pdh_dma_arbiter_if -- requester and DMA-side bus of the two-way DMA arbiter.
//
// Handshake rules (one place for all of them):
//   * Requester n offers a word by raising req_valid_i[n] with the word on
//     req_data_i[n*DATA_WIDTH +: DATA_WIDTH]. The word moves on a rising edge
//     where req_valid_i[n] and req_ready_o[n] are both high. At most one
//     req_ready_o bit is high in any cycle.
//   * dma_enable_o high means dma_data_o holds a word for the DMA controller.
//     It stays high, with dma_data_o stable, until the controller pulses
//     dma_finished_i for one cycle to say the word is committed.
//   * dma_enable_o then drops for at least one cycle before the next word.
//
// The slave modport is the arbiter; the master modport is its environment
// (the requesters plus the DMA controller).
interface pdh_dma_arbiter_if #(
   parameter int DATA_WIDTH = 64
);
   logic [1:0]              req_valid_i;
   logic [2*DATA_WIDTH-1:0] req_data_i;
   logic [1:0]              req_ready_o;
   logic                    dma_enable_o;
   logic [DATA_WIDTH-1:0]   dma_data_o;
   logic                    dma_finished_i;

   modport master (
      output req_valid_i, req_data_i, dma_finished_i,
      input  req_ready_o, dma_enable_o, dma_data_o
   );

   modport slave (
      input  req_valid_i, req_data_i, dma_finished_i,
      output req_ready_o, dma_enable_o, dma_data_o
   );
endinterface

// File: rtl/pdh_dma_arbiter.sv
// pdh_dma_arbiter -- round-robin arbiter feeding words from two requesters
// into one DMA controller, one word in flight at a time, with bursts of up to
// BURST_WORDS words per grant and per-requester commit counters.
//
// Optional feature: define PDH_DMA_ARB_TIMEOUT_EN to enable a watchdog that
// abandons a word after TIMEOUT_CYCLES BUSY cycles without dma_finished_i and
// raises the sticky err_timeout_o flag. Without it err_timeout_o is 0.
//
// state_o is a debug view of the FSM: 0 = IDLE, 1 = BUSY, 2 = NEXT.
module pdh_dma_arbiter #(
   parameter int DATA_WIDTH     = 64,
   parameter int BURST_WORDS    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                aclk,
   input  logic                rst_ni,
   pdh_dma_arbiter_if.slave    bus,
   input  logic                clr_i,
   output logic                grant_o,
   output logic                busy_o,
   output logic [31:0]         cnt0_o,
   output logic [31:0]         cnt1_o,
   output logic                err_timeout_o,
   output logic [1:0]          state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_NEXT = 2'd2
   } state_t;

   localparam int BW = $clog2(BURST_WORDS + 1);
   typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] wd_t;

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_q, last_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] word0, word1;
   logic [1:0]            ready;
   logic                  commit;
   logic                  timeout;
   logic [31:0]           cnt0_q, cnt1_q;

   assign word0 = bus.req_data_i[DATA_WIDTH-1:0];
   assign word1 = bus.req_data_i[2*DATA_WIDTH-1:DATA_WIDTH];

   // Arbitration, burst continuation and commit decisions.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      data_d  = data_q;
      ready   = 2'b00;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid_i != 2'b00) begin
               // Both valid: the one that did not go last wins.
               if (bus.req_valid_i == 2'b11) grant_d = ~last_q;
               else                          grant_d = bus.req_valid_i[1];
               ready[grant_d] = 1'b1;
               data_d  = grant_d ? word1 : word0;
               beat_d  = BW'(1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.dma_finished_i) begin
               commit  = 1'b1;
               state_d = S_NEXT;
            end else if (timeout) begin
               last_d  = grant_q;
               state_d = S_IDLE;
            end
         end
         S_NEXT: begin
            if ((beat_q < BW'(BURST_WORDS)) && bus.req_valid_i[grant_q]) begin
               ready[grant_q] = 1'b1;
               data_d  = grant_q ? word1 : word0;
               beat_d  = beat_q + BW'(1);
               state_d = S_BUSY;
            end else begin
               last_d  = grant_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge aclk or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Grant, round-robin history, beat count and pending word.
   always_ff @(posedge aclk or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         beat_q  <= '0;
         data_q  <= '0;
      end else begin
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         data_q  <= data_d;
      end
   end

   // Commit counters; clear beats a same-cycle commit.
   always_ff @(posedge aclk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (clr_i) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (commit) begin
         if (grant_q) cnt1_q <= cnt1_q + 32'd1;
         else         cnt0_q <= cnt0_q + 32'd1;
      end
   end

`ifdef PDH_DMA_ARB_TIMEOUT_EN
   wd_t  wd_q;
   logic err_q;

   assign timeout = (state_q == S_BUSY) && !bus.dma_finished_i &&
                    (wd_q == wd_t'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts consecutive BUSY cycles without a commit.
   always_ff @(posedge aclk or negedge rst_ni) begin
      if (!rst_ni)                                          wd_q <= '0;
      else if ((state_q != S_BUSY) || bus.dma_finished_i || timeout) wd_q <= '0;
      else                                                  wd_q <= wd_q + wd_t'(1);
   end

   // Sticky timeout flag, cleared only by clr_i or reset.
   always_ff @(posedge aclk or negedge rst_ni) begin
      if (!rst_ni)      err_q <= 1'b0;
      else if (clr_i)   err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
   end

   assign err_timeout_o = err_q;
`else
   assign timeout       = 1'b0;
   assign err_timeout_o = 1'b0;
`endif

   // Ready is forced low while reset is held, even if requesters are valid.
   assign bus.req_ready_o  = rst_ni ? ready : 2'b00;
   assign bus.dma_enable_o = (state_q == S_BUSY);
   assign bus.dma_data_o   = data_q;
   assign grant_o          = grant_q;
   assign busy_o           = (state_q != S_IDLE);
   assign cnt0_o           = cnt0_q;
   assign cnt1_o           = cnt1_q;
   assign state_o          = state_q;

endmodule
